// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - ID stage: control decode, register file, registered ID/EX boundary.
// Optional same-cycle write-back bypass on the read ports: define DECODE_WB_BYPASS_EN.
module decode_stage #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       in_instr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              ex_ready,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_write,
  output logic              ex_mem_read,
  output logic              ex_alu_src,
  output logic              ex_mem_to_reg,
  output logic [2:0]        ex_alu_ctrl,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [AW-1:0]     ex_dst,
  output logic              illegal
);

  localparam logic [4:0] OP_LDM = 5'b00001;
  localparam logic [4:0] OP_STD = 5'b00010;
  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_NOT = 5'b00100;
  localparam logic [4:0] OP_NOP = 5'b00101;

  logic [4:0]        opcode;
  logic [AW-1:0]     rs, rt;
  logic              unused_bits;

  assign opcode      = in_instr[31:27];
  assign rs          = in_instr[26 -: AW];
  assign rt          = in_instr[26-AW -: AW];
  assign unused_bits = ^in_instr[26-2*AW:16];

  logic [DATA_W-1:0] regs_q [NREGS];

  logic [2:0] dec_alu;
  logic       dec_rw, dec_mw, dec_mr, dec_as, dec_mtr;
  logic       dec_rrs, dec_rrt, dec_ill;

  always_comb begin
    dec_alu = 3'b100;
    dec_rw  = 1'b0;
    dec_mw  = 1'b0;
    dec_mr  = 1'b0;
    dec_as  = 1'b0;
    dec_mtr = 1'b0;
    dec_rrs = 1'b0;
    dec_rrt = 1'b0;
    dec_ill = 1'b0;
    case (opcode)
      OP_LDM: begin
        dec_alu = 3'b010;
        dec_rw  = 1'b1;
        dec_mr  = 1'b1;
        dec_as  = 1'b1;
        dec_mtr = 1'b1;
      end
      OP_STD: begin
        dec_alu = 3'b011;
        dec_mw  = 1'b1;
        dec_rrs = 1'b1;
        dec_rrt = 1'b1;
      end
      OP_ADD: begin
        dec_alu = 3'b000;
        dec_rw  = 1'b1;
        dec_rrs = 1'b1;
        dec_rrt = 1'b1;
      end
      OP_NOT: begin
        dec_alu = 3'b001;
        dec_rw  = 1'b1;
        dec_rrs = 1'b1;
      end
      OP_NOP: ;
      default: dec_ill = 1'b1;
    endcase
  end

  logic [DATA_W-1:0] rd1, rd2;
`ifdef DECODE_WB_BYPASS_EN
  assign rd1 = (wb_en && wb_addr == rs) ? wb_data : regs_q[rs];
  assign rd2 = (wb_en && wb_addr == rt) ? wb_data : regs_q[rt];
`else
  assign rd1 = regs_q[rs];
  assign rd2 = regs_q[rt];
`endif

  logic              valid_q, rw_q, mw_q, mr_q, as_q, mtr_q, illegal_q;
  logic [2:0]        alu_q;
  logic [DATA_W-1:0] rd1_q, rd2_q, imm_q;
  logic [AW-1:0]     dst_q;

  logic              valid_d, rw_d, mw_d, mr_d, as_d, mtr_d, illegal_d;
  logic [2:0]        alu_d;
  logic [DATA_W-1:0] rd1_d, rd2_d, imm_d;
  logic [AW-1:0]     dst_d;

  logic hazard, accept;

  // Load-use: a load in ID/EX cannot forward to the instruction being decoded.
  assign hazard   = valid_q && mr_q &&
                    ((dec_rrs && rs == dst_q) || (dec_rrt && rt == dst_q));
  assign in_ready = ex_ready && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_d   = valid_q;
    rw_d      = rw_q;
    mw_d      = mw_q;
    mr_d      = mr_q;
    as_d      = as_q;
    mtr_d     = mtr_q;
    alu_d     = alu_q;
    rd1_d     = rd1_q;
    rd2_d     = rd2_q;
    imm_d     = imm_q;
    dst_d     = dst_q;
    illegal_d = illegal_q | (accept & dec_ill);
    if (accept) begin
      valid_d = 1'b1;
      rw_d    = dec_rw;
      mw_d    = dec_mw;
      mr_d    = dec_mr;
      as_d    = dec_as;
      mtr_d   = dec_mtr;
      alu_d   = dec_alu;
      rd1_d   = rd1;
      rd2_d   = rd2;
      imm_d   = DATA_W'($signed(in_instr[15:0]));
      dst_d   = rt;
    end else if (ex_ready || flush) begin
      valid_d = 1'b0;
      rw_d    = 1'b0;
      mw_d    = 1'b0;
      mr_d    = 1'b0;
      as_d    = 1'b0;
      mtr_d   = 1'b0;
      alu_d   = 3'b000;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      valid_q   <= 1'b0;
      rw_q      <= 1'b0;
      mw_q      <= 1'b0;
      mr_q      <= 1'b0;
      as_q      <= 1'b0;
      mtr_q     <= 1'b0;
      alu_q     <= 3'b000;
      rd1_q     <= '0;
      rd2_q     <= '0;
      imm_q     <= '0;
      dst_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      if (wb_en) regs_q[wb_addr] <= wb_data;
      valid_q   <= valid_d;
      rw_q      <= rw_d;
      mw_q      <= mw_d;
      mr_q      <= mr_d;
      as_q      <= as_d;
      mtr_q     <= mtr_d;
      alu_q     <= alu_d;
      rd1_q     <= rd1_d;
      rd2_q     <= rd2_d;
      imm_q     <= imm_d;
      dst_q     <= dst_d;
      illegal_q <= illegal_d;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_reg_write  = rw_q;
  assign ex_mem_write  = mw_q;
  assign ex_mem_read   = mr_q;
  assign ex_alu_src    = as_q;
  assign ex_mem_to_reg = mtr_q;
  assign ex_alu_ctrl   = alu_q;
  assign ex_rd1        = rd1_q;
  assign ex_rd2        = rd2_q;
  assign ex_imm        = imm_q;
  assign ex_dst        = dst_q;
  assign illegal       = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed and random checks of decode_stage against a reference model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, ex_ready, flush, wb_en;
  logic [31:0] in_instr;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        ex_valid, ex_reg_write, ex_mem_write, ex_mem_read, ex_alu_src, ex_mem_to_reg;
  logic [2:0]  ex_alu_ctrl, ex_dst;
  logic [15:0] ex_rd1, ex_rd2, ex_imm;
  logic        illegal;

  decode_stage dut (
    .clk(clk), .reset(reset), .in_instr(in_instr), .in_valid(in_valid), .in_ready(in_ready),
    .ex_ready(ex_ready), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_write(ex_mem_write),
    .ex_mem_read(ex_mem_read), .ex_alu_src(ex_alu_src), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_alu_ctrl(ex_alu_ctrl), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_dst(ex_dst), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference state: what the ID/EX boundary and register file should hold.
  logic [15:0] m_regs [8];
  logic        m_valid, m_ill, rdy_seen;
  logic [7:0]  m_ctrl;
  logic [15:0] m_rd1, m_rd2, m_imm;
  logic [2:0]  m_dst;

  localparam logic [4:0] LDM = 5'd1, STD = 5'd2, ADD = 5'd3, NOT = 5'd4, NOP = 5'd5;

  // {illegal, reads_rs, reads_rt, alu[2:0], reg_write, mem_write, mem_read, alu_src, mem_to_reg}
  function automatic logic [10:0] dec(input logic [4:0] op);
    case (op)
      LDM:     return {3'b000, 3'b010, 5'b10111};
      STD:     return {3'b011, 3'b011, 5'b01000};
      ADD:     return {3'b011, 3'b000, 5'b10000};
      NOT:     return {3'b010, 3'b001, 5'b10000};
      NOP:     return {3'b000, 3'b100, 5'b00000};
      default: return {3'b100, 3'b100, 5'b00000};
    endcase
  endfunction

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [2:0] rs, input logic [2:0] rt,
                                     input logic [15:0] imm);
    logic [4:0] filler;
    filler = 5'($urandom);
    return {op, rs, rt, filler, imm};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step(input logic rst, input logic [31:0] ins, input logic v, input logic er,
                      input logic fl, input logic we, input logic [2:0] wa, input logic [15:0] wd);
    logic [10:0] d;
    logic [2:0]  rs, rt;
    logic        haz, rdy;
    logic [15:0] rd1, rd2;
    reset = rst; in_instr = ins; in_valid = v; ex_ready = er; flush = fl;
    wb_en = we; wb_addr = wa; wb_data = wd;
    #1;
    d   = dec(ins[31:27]);
    rs  = ins[26:24];
    rt  = ins[23:21];
    haz = m_valid && m_ctrl[2] && ((d[9] && rs == m_dst) || (d[8] && rt == m_dst));
    rdy = er && !haz && !fl;
    rdy_seen = in_ready;
    if (v && !rst) chk("in_ready", in_ready, rdy);
    rd1 = m_regs[rs];
    rd2 = m_regs[rt];
`ifdef DECODE_WB_BYPASS_EN
    if (we && wa == rs) rd1 = wd;
    if (we && wa == rt) rd2 = wd;
`endif
    @(posedge clk);
    if (rst) begin
      foreach (m_regs[i]) m_regs[i] = '0;
      m_valid = 0; m_ctrl = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_dst = 0; m_ill = 0;
    end else begin
      if (we) m_regs[wa] = wd;
      if (v && rdy) begin
        m_valid = 1; m_ctrl = d[7:0]; m_rd1 = rd1; m_rd2 = rd2; m_imm = ins[15:0]; m_dst = rt;
        if (d[10]) m_ill = 1;
      end else if (er || fl) begin
        m_valid = 0; m_ctrl = 0;
      end
    end
    #1;
    chk("ex_valid", ex_valid, m_valid);
    chk("ctrl", {ex_alu_ctrl, ex_reg_write, ex_mem_write, ex_mem_read, ex_alu_src, ex_mem_to_reg}, m_ctrl);
    chk("illegal", illegal, m_ill);
    if (m_valid) begin
      chk("ex_rd1", ex_rd1, m_rd1);
      chk("ex_rd2", ex_rd2, m_rd2);
      chk("ex_imm", ex_imm, m_imm);
      chk("ex_dst", ex_dst, m_dst);
    end
  endtask

  initial begin
    logic [31:0] nop_i;
    nop_i = {NOP, 27'd0};
    foreach (m_regs[i]) m_regs[i] = '0;
    m_valid = 0; m_ctrl = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_dst = 0; m_ill = 0;

    step(1, nop_i, 0, 1, 0, 1, 3'd5, 16'h5555);
    step(1, nop_i, 0, 1, 0, 0, 0, 0);
    chk("rst_rd1", ex_rd1, 0);
    chk("rst_rd2", ex_rd2, 0);
    chk("rst_imm", ex_imm, 0);
    chk("rst_dst", ex_dst, 0);

    step(0, mk(ADD, 1, 2, 16'h8001), 1, 1, 0, 0, 0, 0);
    chk("add_rd1", ex_rd1, 0);
    chk("add_alu", ex_alu_ctrl, 3'b000);
    chk("add_rw", ex_reg_write, 1);

    step(0, mk(NOT, 3, 0, 0), 1, 1, 0, 1, 3'd3, 16'hBEEF);
`ifdef DECODE_WB_BYPASS_EN
    chk("wb_same_cycle", ex_rd1, 16'hBEEF);
`else
    chk("wb_same_cycle", ex_rd1, 16'h0000);
`endif
    step(0, mk(NOT, 3, 0, 0), 1, 1, 0, 0, 0, 0);
    chk("wb_next_cycle", ex_rd1, 16'hBEEF);

    step(0, mk(LDM, 0, 4, 16'h0042), 1, 1, 0, 0, 0, 0);
    chk("ldm_mr", ex_mem_read, 1);
    step(0, mk(ADD, 4, 2, 0), 1, 1, 0, 1, 3'd4, 16'h1234);
    chk("loaduse_ready", rdy_seen, 0);
    chk("loaduse_bubble", ex_valid, 0);
    step(0, mk(ADD, 4, 2, 0), 1, 1, 0, 0, 0, 0);
    chk("loaduse_ready2", rdy_seen, 1);
    chk("loaduse_rd1", ex_rd1, 16'h1234);

    step(0, mk(STD, 1, 3, 16'h0007), 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, mk(ADD, 5, 6, 0), 1, 0, 0, 0, 0, 0);
      chk("stall_ready", rdy_seen, 0);
      chk("stall_mw", ex_mem_write, 1);
    end
    step(0, mk(ADD, 5, 6, 0), 1, 1, 0, 0, 0, 0);
    chk("stall_release", ex_reg_write, 1);

    step(0, {5'b11111, 27'h0ABCDEF}, 1, 1, 0, 0, 0, 0);
    chk("ill_flag", illegal, 1);
    chk("ill_valid", ex_valid, 1);
    for (int i = 0; i < 5; i++) begin
      step(0, mk(NOT, 3'(i), 0, 16'(i)), 1, 1, 0, 0, 0, 0);
      chk("ill_sticky", illegal, 1);
    end

    step(0, mk(ADD, 1, 2, 0), 1, 1, 0, 0, 0, 0);
    step(0, mk(ADD, 2, 3, 0), 1, 0, 0, 0, 0, 0);
    step(0, mk(ADD, 2, 3, 0), 1, 0, 1, 0, 0, 0);
    chk("flush_valid", ex_valid, 0);

    step(0, mk(ADD, 1, 1, 0), 1, 1, 0, 0, 0, 0);
    step(0, mk(ADD, 2, 2, 0), 1, 0, 0, 0, 0, 0);
    step(1, mk(ADD, 2, 2, 0), 1, 0, 0, 1, 3'd2, 16'h7777);
    chk("rst_stall_valid", ex_valid, 0);
    chk("rst_stall_ill", illegal, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, mk(ADD, 3'(i), 3'(7 - i), 0), 1, 1, 0, 0, 0, 0);
      chk("rst_regs_rs", ex_rd1, 0);
      chk("rst_regs_rt", ex_rd2, 0);
    end

    for (int n = 0; n < 400; n++) begin
      logic [4:0] op;
      int r;
      r  = int'($urandom_range(0, 11));
      op = (r < 10) ? 5'(1 + r % 5) : 5'($urandom);
      step(($urandom % 100) == 0, mk(op, 3'($urandom), 3'($urandom), 16'($urandom)),
           ($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 16) == 0,
           1'($urandom), 3'($urandom), 16'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
